// File: rtl/dac_pkg.sv
// Shared constants, FSM state type and frame builder for the DAC SPI transmitter.
package dac_pkg;

  localparam int unsigned DAC_BITS   = 12;
  localparam int unsigned FRAME_BITS = 16;
  localparam logic [15:0] DAC_MAX    = 16'h0FFF;

  // Channel A, unbuffered, gain 1x, active.
  localparam logic [3:0] CFG_BITS_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StShift,
    StCsHold,
    StLdac,
    StDone
  } dac_state_e;

  // Build the 16-bit SPI word, saturating the code to the DAC's 12-bit range.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [3:0]  cfg,
                                                       input logic [15:0] data);
    logic [DAC_BITS-1:0] code;
    code = (data > DAC_MAX) ? {DAC_BITS{1'b1}} : data[DAC_BITS-1:0];
    return {cfg, code};
  endfunction

endpackage

// File: rtl/dac_sclk_tick.sv
// Half-period tick generator: pulses every ClkDiv cycles, restartable from zero.
module dac_sclk_tick #(
  parameter int unsigned ClkDiv = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic tick_o
);

  logic [7:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == 8'(ClkDiv - 1));

  // Next count: hold at zero while restarting, wrap on every tick.
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (restart_i || tick_o) begin
      cnt_d = 8'd0;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// SPI frame transmitter for a 12-bit DAC with CS/LDAC sequencing and a one-word pending slot.
module dac_spi_tx
  import dac_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [3:0]  CFG_BITS = CFG_BITS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PID_Done,
  input  logic [15:0] i_data,
  output logic        busy,
  output logic        done,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_sdi,
  output logic        dac_ldac_n
);

  dac_state_e            state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [FRAME_BITS-1:0] pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [3:0]            bit_q, bit_d;
  logic                  phase_q, phase_d;  // current SCLK level during StShift
  logic                  tick;
  logic                  restart;
  logic [FRAME_BITS-1:0] new_frame;

  assign new_frame = make_frame(CFG_BITS, i_data);

  // Keep the divider parked so every frame starts with a full setup period.
  assign restart = (state_q == StIdle) || (state_q == StDone);

  dac_sclk_tick #(
    .ClkDiv (CLK_DIV)
  ) u_tick (
    .clk_i     (clk),
    .rst_i     (reset),
    .restart_i (restart),
    .tick_o    (tick)
  );

  // Next-state, shift and pending-slot logic.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    bit_d      = bit_q;
    phase_d    = phase_q;

    // Words arriving mid-frame park here; the latest one wins.
    if (PID_Done && (state_q != StIdle)) begin
      pend_d     = new_frame;
      pend_vld_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (PID_Done) begin
          frame_d = new_frame;
          bit_d   = 4'd0;
          phase_d = 1'b0;
          state_d = StCsSetup;
        end
      end
      StCsSetup: begin
        if (tick) state_d = StShift;
      end
      StShift: begin
        if (tick) begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // Advance data only as SCLK falls so SDI is stable while high.
            phase_d = 1'b0;
            frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
            if (bit_q == 4'd15) begin
              state_d = StCsHold;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end
      end
      StCsHold: begin
        if (tick) state_d = StLdac;
      end
      StLdac: begin
        if (tick) state_d = StDone;
      end
      StDone: begin
        bit_d   = 4'd0;
        phase_d = 1'b0;
        if (PID_Done) begin
          // A word arriving now is newer than anything parked.
          frame_d    = new_frame;
          pend_vld_d = 1'b0;
          state_d    = StCsSetup;
        end else if (pend_vld_q) begin
          frame_d    = pend_q;
          pend_vld_d = 1'b0;
          state_d    = StCsSetup;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      frame_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      bit_q      <= 4'd0;
      phase_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    dac_cs_n   = 1'b1;
    dac_sclk   = 1'b0;
    dac_sdi    = 1'b0;
    dac_ldac_n = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StCsSetup: begin
        dac_cs_n = 1'b0;
        dac_sdi  = frame_q[FRAME_BITS-1];
        busy     = 1'b1;
      end
      StShift: begin
        dac_cs_n = 1'b0;
        dac_sclk = phase_q;
        dac_sdi  = frame_q[FRAME_BITS-1];
        busy     = 1'b1;
      end
      StCsHold: begin
        dac_cs_n = 1'b0;
        busy     = 1'b1;
      end
      StLdac: begin
        dac_ldac_n = 1'b0;
        busy       = 1'b1;
      end
      StDone: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: frame timing, clamping, pending overwrite, reset abort, CLK_DIV=2.
module tb_dac_spi_tx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pid1 = 1'b0, pid2 = 1'b0;
  logic [15:0] data1 = '0, data2 = '0;
  logic busy1, done1, cs_n1, sclk1, sdi1, ldac1;
  logic busy2, done2, cs_n2, sclk2, sdi2, ldac2;

  always #5 clk = ~clk;

  dac_spi_tx #(.CLK_DIV(4)) u_dut1 (
    .clk(clk), .reset(reset), .PID_Done(pid1), .i_data(data1),
    .busy(busy1), .done(done1), .dac_cs_n(cs_n1), .dac_sclk(sclk1),
    .dac_sdi(sdi1), .dac_ldac_n(ldac1)
  );

  dac_spi_tx #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .reset(reset), .PID_Done(pid2), .i_data(data2),
    .busy(busy2), .done(done2), .dac_cs_n(cs_n2), .dac_sclk(sclk2),
    .dac_sdi(sdi2), .dac_ldac_n(ldac2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observers: reconstruct frames and timing from the pins, sampled mid-cycle.
  int nf1 = 0, len1 = 0, nb1 = 0, viol1 = 0, nldac1 = 0, ldac_fall1 = 0, ldac_len1 = 0;
  int ndone1 = 0, done_cyc1 = 0;
  logic done_busy1 = 1'b0;
  logic [15:0] sh1 = '0;
  logic hi1 = 1'b0, pcs1 = 1'b1, psclk1 = 1'b0, pldac1 = 1'b1;
  int cs_fall1 [32];
  int cs_len1 [32];
  int bits1 [32];
  logic [15:0] frames1 [32];

  always @(negedge clk) begin
    if (!cs_n1) begin
      if (pcs1) begin
        cs_fall1[nf1] = cyc; len1 = 0; sh1 = '0; nb1 = 0;
      end
      len1++;
    end else if (!pcs1 && nf1 < 31) begin
      frames1[nf1] = sh1; bits1[nf1] = nb1; cs_len1[nf1] = len1; nf1++;
    end
    if (sclk1 && !psclk1) begin
      sh1 = {sh1[14:0], sdi1}; nb1++; hi1 = sdi1;
    end else if (sclk1 && sdi1 !== hi1) begin
      viol1++;
    end
    if (!ldac1) begin
      if (pldac1) begin
        ldac_fall1 = cyc; ldac_len1 = 0; nldac1++;
      end
      ldac_len1++;
    end
    if (done1) begin
      done_cyc1 = cyc; done_busy1 = busy1; ndone1++;
    end
    pcs1 = cs_n1; psclk1 = sclk1; pldac1 = ldac1;
  end

  int nf2 = 0, len2 = 0, viol2 = 0, last_rise2 = -1, pmin2 = 999, pmax2 = 0;
  int cs_len2 = 0, pmin2_f = 0, pmax2_f = 0;
  logic [15:0] sh2 = '0, frame2 = '0;
  logic hi2 = 1'b0, pcs2 = 1'b1, psclk2 = 1'b0;

  always @(negedge clk) begin
    if (!cs_n2) begin
      if (pcs2) begin
        len2 = 0; sh2 = '0; last_rise2 = -1; pmin2 = 999; pmax2 = 0;
      end
      len2++;
    end else if (!pcs2) begin
      frame2 = sh2; cs_len2 = len2; pmin2_f = pmin2; pmax2_f = pmax2; nf2++;
    end
    if (sclk2 && !psclk2) begin
      sh2 = {sh2[14:0], sdi2}; hi2 = sdi2;
      if (last_rise2 >= 0) begin
        if (cyc - last_rise2 < pmin2) pmin2 = cyc - last_rise2;
        if (cyc - last_rise2 > pmax2) pmax2 = cyc - last_rise2;
      end
      last_rise2 = cyc;
    end else if (sclk2 && sdi2 !== hi2) begin
      viol2++;
    end
    pcs2 = cs_n2; psclk2 = sclk2;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [15:0] d);
    pid1 = 1'b1; data1 = d;
    tick(1);
    pid1 = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget, input bit sel2);
    int i;
    for (i = 0; i < budget; i++) begin
      if (sel2 ? (!busy2 && !done2) : (!busy1 && !done1)) break;
      tick(1);
    end
    chk(tag, 32'(i < budget), 32'd1);
    tick(2);
  endtask

  int t0, fb, nd0, nl0;

  initial begin
    tick(3);
    // Reset state while reset is held.
    chk("rst_cs_n", 32'(cs_n1), 32'd1);
    chk("rst_sclk", 32'(sclk1), 32'd0);
    chk("rst_sdi", 32'(sdi1), 32'd0);
    chk("rst_ldac", 32'(ldac1), 32'd1);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    reset = 1'b0;
    tick(2);

    // Single word 0x0ABC, CLK_DIV=4.
    t0 = cyc; fb = nf1; nd0 = ndone1;
    send1(16'h0ABC);
    chk("c1_busy", 32'(busy1), 32'd1);
    chk("c1_cs_n", 32'(cs_n1), 32'd0);
    wait_idle("single_timeout", 400, 1'b0);
    chk("single_cs_fall", 32'(cs_fall1[fb] - t0), 32'd1);
    chk("single_cs_len", 32'(cs_len1[fb]), 32'd136);
    chk("single_frame", 32'(frames1[fb]), 32'h3ABC);
    chk("single_bits", 32'(bits1[fb]), 32'd16);
    chk("single_ldac_fall", 32'(ldac_fall1 - t0), 32'd137);
    chk("single_ldac_len", 32'(ldac_len1), 32'd4);
    chk("single_done_cyc", 32'(done_cyc1 - t0), 32'd141);
    chk("single_done_cnt", 32'(ndone1 - nd0), 32'd1);
    chk("single_done_busy", 32'(done_busy1), 32'd0);
    chk("single_sdi_stable", 32'(viol1), 32'd0);

    // Clamping.
    send1(16'h8001);
    wait_idle("clamp0_timeout", 400, 1'b0);
    chk("clamp_8001", 32'(frames1[nf1-1]), 32'h3FFF);
    send1(16'h1000);
    wait_idle("clamp1_timeout", 400, 1'b0);
    chk("clamp_1000", 32'(frames1[nf1-1]), 32'h3FFF);
    send1(16'h0000);
    wait_idle("clamp2_timeout", 400, 1'b0);
    chk("clamp_0000", 32'(frames1[nf1-1]), 32'h3000);

    // Pending overwrite: latest parked word wins.
    t0 = cyc; fb = nf1;
    send1(16'h0111);
    tick(9);
    send1(16'h0222);
    tick(9);
    send1(16'h0333);
    wait_idle("pend_timeout", 600, 1'b0);
    chk("pend_nframes", 32'(nf1 - fb), 32'd2);
    chk("pend_frame0", 32'(frames1[fb]), 32'h3111);
    chk("pend_frame1", 32'(frames1[fb+1]), 32'h3333);
    chk("pend_cs2_fall", 32'(cs_fall1[fb+1] - t0), 32'd142);
    chk("pend_cs2_len", 32'(cs_len1[fb+1]), 32'd136);

    // Reset mid-frame at cycle 50.
    t0 = cyc;
    send1(16'h0555);
    tick(49);
    nd0 = ndone1; nl0 = nldac1;
    reset = 1'b1;
    tick(1);
    chk("mrst_cs_n", 32'(cs_n1), 32'd1);
    chk("mrst_sclk", 32'(sclk1), 32'd0);
    chk("mrst_ldac", 32'(ldac1), 32'd1);
    chk("mrst_busy", 32'(busy1), 32'd0);
    chk("mrst_sdi", 32'(sdi1), 32'd0);
    reset = 1'b0;
    tick(200);
    chk("mrst_no_done", 32'(ndone1 - nd0), 32'd0);
    chk("mrst_no_ldac", 32'(nldac1 - nl0), 32'd0);
    fb = nf1;
    send1(16'h0123);
    wait_idle("mrst_timeout", 400, 1'b0);
    chk("mrst_frame", 32'(frames1[fb]), 32'h3123);
    chk("mrst_cs_len", 32'(cs_len1[fb]), 32'd136);
    chk("mrst_done", 32'(ndone1 - nd0), 32'd1);

    // CLK_DIV=2 timing.
    pid2 = 1'b1; data2 = 16'h05A3;
    tick(1);
    pid2 = 1'b0;
    wait_idle("div2_timeout", 400, 1'b1);
    chk("div2_nframes", 32'(nf2), 32'd1);
    chk("div2_frame", 32'(frame2), 32'h35A3);
    chk("div2_cs_len", 32'(cs_len2), 32'd68);
    chk("div2_per_min", 32'(pmin2_f), 32'd4);
    chk("div2_per_max", 32'(pmax2_f), 32'd4);
    chk("div2_sdi_stable", 32'(viol2), 32'd0);
    chk("all_sdi_stable", 32'(viol1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
